weight_buffer_stream: RTL and testbench

Parametrised weight memory for the TPU. It feeds the systolic array with weight rows. Port 0 is a random-access read/write port with per-byte write enables, used by the host/DMA loader. Port 1 is an autonomous burst-read engine that streams consecutive rows to the weight FIFO. Both read paths use a configurable output pipeline, and each has a valid flag so that downstream logic no longer counts cycles.

---
 rtl/weight_buffer_stream.sv | 159 +++++++++++++++
 tb/tb_weight_buffer_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer_stream.sv
// Weight row memory: byte-masked random-access port 0 plus an autonomous burst-read stream port 1.
// Optional sticky write/stream collision flag when WEIGHT_BUFFER_COLLISION_EN is defined.
module weight_buffer_stream #(
    parameter int unsigned MATRIX_WIDTH = 14,
    parameter int unsigned BYTE_WIDTH   = 8,
    parameter int unsigned DEPTH        = 32768,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_BURST    = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [$clog2(DEPTH)-1:0]             addr0,
    input  logic                                 en0,
    input  logic                                 we0,
    input  logic [MATRIX_WIDTH-1:0]              wbe0,
    input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]   wdata0,
    output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]   rdata0,
    output logic                                 rvalid0,
    input  logic                                 burst_start,
    input  logic [$clog2(DEPTH)-1:0]             burst_addr,
    input  logic [$clog2(MAX_BURST+1)-1:0]       burst_len,
    output logic                                 burst_busy,
    output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]   rdata1,
    output logic                                 rvalid1,
    output logic                                 rlast1
`ifdef WEIGHT_BUFFER_COLLISION_EN
    ,
    output logic                                 collision_err
`endif
);

    localparam int unsigned DW = MATRIX_WIDTH * BYTE_WIDTH;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [DW-1:0]          mem [DEPTH];
    state_t                 state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [LW-1:0]          cnt_q, cnt_d;
    logic                   busy_q;
    logic                   rd1_c, last1_c;
    logic                   addr0_ok_c, ptr_ok_c, len_ok_c;

    logic [DW-1:0]          d0_pipe [READ_LATENCY+1];
    logic [READ_LATENCY:0]  v0_pipe;
    logic [DW-1:0]          d1_pipe [READ_LATENCY+1];
    logic [READ_LATENCY:0]  v1_pipe;
    logic [READ_LATENCY:0]  l1_pipe;

    assign addr0_ok_c = 32'(addr0) < DEPTH;
    assign ptr_ok_c   = 32'(ptr_q) < DEPTH;
    assign len_ok_c   = (burst_len != '0) && (32'(burst_len) <= MAX_BURST);

    // Byte-masked write; reads below sample the pre-write contents.
    always_ff @(posedge clk) begin
        if (enable && en0 && we0 && addr0_ok_c) begin
            for (int i = 0; i < MATRIX_WIDTH; i++) begin
                if (wbe0[i]) begin
                    mem[addr0][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata0[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Port 0 RAM register followed by READ_LATENCY output stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_pipe <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) d0_pipe[i] <= '0;
        end else if (enable) begin
            v0_pipe <= {v0_pipe[READ_LATENCY-1:0], en0};
            if (en0) d0_pipe[0] <= addr0_ok_c ? mem[addr0] : '0;
            for (int i = 1; i <= READ_LATENCY; i++) d0_pipe[i] <= d0_pipe[i-1];
        end
    end

    assign rdata0  = d0_pipe[READ_LATENCY];
    assign rvalid0 = v0_pipe[READ_LATENCY];

    // Port 1 stream pipeline; rlast travels with its beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_pipe <= '0;
            l1_pipe <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) d1_pipe[i] <= '0;
        end else if (enable) begin
            v1_pipe <= {v1_pipe[READ_LATENCY-1:0], rd1_c};
            l1_pipe <= {l1_pipe[READ_LATENCY-1:0], last1_c};
            if (rd1_c) d1_pipe[0] <= ptr_ok_c ? mem[ptr_q] : '0;
            for (int i = 1; i <= READ_LATENCY; i++) d1_pipe[i] <= d1_pipe[i-1];
        end
    end

    assign rdata1     = d1_pipe[READ_LATENCY];
    assign rvalid1    = v1_pipe[READ_LATENCY];
    assign rlast1     = l1_pipe[READ_LATENCY];
    assign burst_busy = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == RUN);
        end
    end

    // Burst engine: one read per enabled edge in RUN, leaving RUN on the final read.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rd1_c   = 1'b0;
        last1_c = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (burst_start && len_ok_c) begin
                        state_d = RUN;
                        ptr_d   = burst_addr;
                        cnt_d   = burst_len;
                    end
                end
                RUN: begin
                    rd1_c   = 1'b1;
                    last1_c = (cnt_q == LW'(1));
                    cnt_d   = cnt_q - LW'(1);
                    ptr_d   = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
                    if (cnt_q == LW'(1)) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef WEIGHT_BUFFER_COLLISION_EN
    logic coll_q;

    // Sticky flag: host write hits the row the stream reads on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q <= 1'b0;
        end else if (enable && en0 && we0 && (state_q == RUN) && (addr0 == ptr_q)) begin
            coll_q <= 1'b1;
        end
    end

    assign collision_err = coll_q;
`endif

endmodule

// File: tb/tb_weight_buffer_stream.sv
// Scoreboard bench for weight_buffer_stream: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_weight_buffer_stream;
    localparam int unsigned MW    = 14;
    localparam int unsigned BW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned RL    = 2;
    localparam int unsigned MB    = 8;
    localparam int unsigned DW    = MW * BW;
    localparam int unsigned AW    = 4;
    localparam int unsigned LW    = 4;

    logic          clk = 1'b0;
    logic          rst, enable, en0, we0, burst_start;
    logic [AW-1:0] addr0, burst_addr;
    logic [MW-1:0] wbe0;
    logic [DW-1:0] wdata0, rdata0, rdata1;
    logic [LW-1:0] burst_len;
    logic          rvalid0, rvalid1, rlast1, burst_busy;
`ifdef WEIGHT_BUFFER_COLLISION_EN
    logic          collision_err;
`endif

    weight_buffer_stream #(
        .MATRIX_WIDTH(MW), .BYTE_WIDTH(BW), .DEPTH(DEPTH), .READ_LATENCY(RL), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .addr0(addr0), .en0(en0), .we0(we0), .wbe0(wbe0), .wdata0(wdata0),
        .rdata0(rdata0), .rvalid0(rvalid0),
        .burst_start(burst_start), .burst_addr(burst_addr), .burst_len(burst_len),
        .burst_busy(burst_busy), .rdata1(rdata1), .rvalid1(rvalid1), .rlast1(rlast1)
`ifdef WEIGHT_BUFFER_COLLISION_EN
        , .collision_err(collision_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        bit            chk;
        int            lat;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    int            checks = 0;
    int            errors = 0;
    int            edge_n = 0;
    int            seen1  = 0;
    bit            last_en = 1'b0;
    logic [DW-1:0] shadow [DEPTH];
    bit            known  [DEPTH];
    logic [DW-1:0] prev0, prev1;
    logic          prevv0, prevv1;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] fill(input int r);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < MW; i++) v[i*BW +: BW] = {4'(r), 4'(i)};
        return v;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        last_en <= enable;
    end

    // Monitor: a new beat is one presented after an enabled edge; stalled edges must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!last_en) begin
            if (prevv1) begin
                check("stall_hold_valid1", DW'(rvalid1), DW'(prevv1));
                check("stall_hold_data1", rdata1, prev1);
            end
            if (prevv0) check("stall_hold_data0", rdata0, prev0);
        end else begin
            if (rvalid0 === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL p0_unexpected: got beat %h expected none", rdata0);
                end else begin
                    e = q0.pop_front();
                    if (e.chk) check("p0_data", rdata0, e.data);
                    if (e.lat >= 0) check("p0_latency", DW'(edge_n), DW'(e.lat));
                end
            end
            if (rvalid1 === 1'b1) begin
                seen1++;
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL p1_unexpected: got beat %h expected none", rdata1);
                end else begin
                    e = q1.pop_front();
                    if (e.chk) check("p1_data", rdata1, e.data);
                    check("p1_rlast", DW'(rlast1), DW'(e.last));
                    if (e.lat >= 0) check("p1_first_latency", DW'(edge_n), DW'(e.lat));
                end
            end
        end
        prev0  = rdata0;
        prev1  = rdata1;
        prevv0 = rvalid0;
        prevv1 = rvalid1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic p0(input logic [AW-1:0] a, input bit we, input logic [MW-1:0] be,
                      input logic [DW-1:0] wd, input bit fixed, input logic [DW-1:0] fexp);
        exp_t e;
        e.data = fixed ? fexp : shadow[a];
        e.chk  = fixed || known[a];
        e.last = 1'b0;
        e.lat  = edge_n + 3;
        q0.push_back(e);
        if (we) begin
            for (int i = 0; i < MW; i++) if (be[i]) shadow[a][i*BW +: BW] = wd[i*BW +: BW];
            if (be == '1) known[a] = 1'b1;
        end
        addr0 = a; en0 = 1'b1; we0 = we; wbe0 = be; wdata0 = wd;
        step();
        en0 = 1'b0; we0 = 1'b0;
    endtask

    task automatic burst(input logic [AW-1:0] a, input logic [LW-1:0] n, input bit push, input bit lat);
        exp_t e;
        logic [AW-1:0] row;
        if (push) begin
            for (int k = 0; k < int'(n); k++) begin
                row    = AW'(int'(a) + k);
                e.data = shadow[row];
                e.chk  = known[row];
                e.last = (k == int'(n) - 1);
                e.lat  = (lat && k == 0) ? edge_n + 4 : -1;
                q1.push_back(e);
            end
        end
        burst_start = 1'b1; burst_addr = a; burst_len = n;
        step();
        burst_start = 1'b0;
    endtask

    task automatic count_busy(input bit inject, output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (burst_busy) n++;
            if (inject && i == 1) begin
                burst_start = 1'b1; burst_addr = '0; burst_len = LW'(2);
            end
            step();
            burst_start = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst = 1'b1; enable = 1'b1; en0 = 1'b0; we0 = 1'b0; wbe0 = '0; wdata0 = '0; addr0 = '0;
        burst_start = 1'b0; burst_addr = '0; burst_len = '0;
        for (int i = 0; i < DEPTH; i++) begin shadow[i] = '0; known[i] = 1'b0; end
        repeat (3) step();

        check("reset_rdata0", rdata0, '0);
        check("reset_rvalid0", DW'(rvalid0), '0);
        check("reset_rdata1", rdata1, '0);
        check("reset_rvalid1", DW'(rvalid1), '0);
        check("reset_rlast1", DW'(rlast1), '0);
        check("reset_busy", DW'(burst_busy), '0);
`ifdef WEIGHT_BUFFER_COLLISION_EN
        check("reset_collision", DW'(collision_err), '0);
`endif
        rst = 1'b0;

        for (int r = 0; r < DEPTH; r++) p0(AW'(r), 1'b1, '1, fill(r), 1'b0, '0);

        // Byte-enable rewrite of row 5
        p0(AW'(5), 1'b1, '1, 112'h0E0D0C0B0A0908070605040302_01, 1'b0, '0);
        p0(AW'(5), 1'b1, 14'h0001, DW'(8'hFF), 1'b0, '0);
        p0(AW'(5), 1'b0, '0, '0, 1'b1, 112'h0E0D0C0B0A0908070605040302_FF);
        repeat (6) step();

        // Wrapping burst 14,15,0,1
        burst(AW'(14), LW'(4), 1'b1, 1'b1);
        count_busy(1'b0, n);
        check("wrap_busy_cycles", DW'(n), DW'(4));

        // Stall mid-burst
        burst(AW'(2), LW'(6), 1'b1, 1'b0);
        repeat (4) step();
        enable = 1'b0;
        repeat (5) step();
        check("stall_busy_held", DW'(burst_busy), DW'(1));
        enable = 1'b1;
        repeat (10) step();

        // Ignored requests
        burst('0, LW'(0), 1'b0, 1'b0);
        count_busy(1'b0, n);
        check("len0_busy_cycles", DW'(n), DW'(0));
        burst('0, LW'(9), 1'b0, 1'b0);
        count_busy(1'b0, n);
        check("len_over_busy_cycles", DW'(n), DW'(0));
        burst(AW'(8), LW'(3), 1'b1, 1'b0);
        count_busy(1'b1, n);
        check("start_in_run_busy_cycles", DW'(n), DW'(3));

        // Reset during beat 2 of an 8-row burst
        base = seen1;
        burst('0, LW'(8), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (seen1 >= base + 2) break;
        end
        check("reset_burst_beats_seen", DW'(seen1 - base), DW'(2));
        rst = 1'b1;
        q1.delete();
        step();
        check("midrst_rvalid1", DW'(rvalid1), '0);
        check("midrst_rvalid0", DW'(rvalid0), '0);
        check("midrst_busy", DW'(burst_busy), '0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("midrst_no_rlast", DW'(rlast1), '0);
            step();
        end

`ifdef WEIGHT_BUFFER_COLLISION_EN
        // Write hits the streamed row on the same edge
        check("coll_clear", DW'(collision_err), '0);
        burst(AW'(3), LW'(4), 1'b1, 1'b0);
        p0(AW'(10), 1'b1, '1, {14{8'h55}}, 1'b0, '0);
        check("coll_no_false", DW'(collision_err), '0);
        p0(AW'(4), 1'b1, '1, {14{8'hAA}}, 1'b0, '0);
        check("coll_set", DW'(collision_err), DW'(1));
        repeat (10) step();
        check("coll_sticky", DW'(collision_err), DW'(1));
        rst = 1'b1;
        step();
        check("coll_rst", DW'(collision_err), '0);
        rst = 1'b0;
`endif

        repeat (10) step();
        check("q0_drained", DW'(q0.size()), '0);
        check("q1_drained", DW'(q1.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
